// File: rtl/mips_unified_mem.sv
// Unified byte-addressed, big-endian instruction/data memory for the multicycle MIPS core.
// Clears itself after reset, accepts a preload while the core is held in reset, then runs it.
module mips_unified_mem #(
  parameter int MEM_BYTES = 128,
  parameter int IDX_W     = 7
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  input  logic        memwrite,
  output logic [31:0] rd,
  output logic        core_reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata,
  output logic [1:0]  state,
  output logic [31:0] run_cycles
);

  localparam int CW = IDX_W - 2;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_BOOT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [31:0]       run_cycles_q, run_cycles_d;
  logic [31:0]       rd_q, dbg_q;
  logic              core_reset_q, load_ready_q;
  logic [7:0]        mem_q [MEM_BYTES];

  logic              we_s;
  logic [IDX_W-1:0]  wa_s;
  logic [31:0]       wdata_s;
  logic [IDX_W-1:0]  rd_a_s;
  logic              unused_s;

  function automatic logic [IDX_W-1:0] byte_idx(input logic [IDX_W-1:0] base, input logic [1:0] off);
    byte_idx = base + {{(IDX_W-2){1'b0}}, off};
  endfunction

  // Big-endian word fetch; byte indices wrap at the top of the array.
  function automatic logic [31:0] word_at(input logic [IDX_W-1:0] base);
    word_at = {mem_q[byte_idx(base, 2'd0)], mem_q[byte_idx(base, 2'd1)],
               mem_q[byte_idx(base, 2'd2)], mem_q[byte_idx(base, 2'd3)]};
  endfunction

  assign unused_s = ^{adr[31:IDX_W], load_addr[31:IDX_W], load_addr[1:0], dbg_addr[31:IDX_W]};
  assign rd_a_s   = core_reset_q ? {IDX_W{1'b0}} : adr[IDX_W-1:0];

  // Next state and the single write port, honouring RESET > CLEAR > BOOT > RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we_s      = 1'b0;
    wa_s      = {IDX_W{1'b0}};
    wdata_s   = 32'h0000_0000;
    case (state_q)
      S_CLEAR: begin
        we_s      = 1'b1;
        wa_s      = {clr_cnt_q, 2'b00};
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == CNT_LAST) state_d = S_BOOT;
        else                       state_d = S_CLEAR;
      end
      S_BOOT: begin
        if (load_valid) begin
          we_s    = 1'b1;
          wa_s    = {load_addr[IDX_W-1:2], 2'b00};
          wdata_s = load_data;
        end else begin
          we_s    = 1'b0;
        end
        if (load_done) state_d = S_RUN;
        else           state_d = S_BOOT;
      end
      S_RUN: begin
        if (memwrite) begin
          we_s    = 1'b1;
          wa_s    = rd_a_s;
          wdata_s = wd;
        end else begin
          we_s    = 1'b0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    if (RESET) begin
      state_d   = S_CLEAR;
      clr_cnt_d = {CW{1'b0}};
      we_s      = 1'b0;
    end else begin
      we_s      = we_s;
    end
  end

  // Saturating count of cycles spent in RUN.
  always_comb begin
    run_cycles_d = run_cycles_q;
    if (RESET)                                                  run_cycles_d = 32'h0000_0000;
    else if (state_q == S_RUN && run_cycles_q != 32'hFFFF_FFFF) run_cycles_d = run_cycles_q + 32'd1;
    else                                                        run_cycles_d = run_cycles_q;
  end

  // Control registers; reset is already folded into the _d terms.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    clr_cnt_q    <= clr_cnt_d;
    run_cycles_q <= run_cycles_d;
    core_reset_q <= (state_d != S_RUN);
    load_ready_q <= (state_d == S_BOOT);
  end

  // Registered read ports sample the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_q  <= 32'h0000_0000;
      dbg_q <= 32'h0000_0000;
    end else begin
      rd_q  <= word_at(rd_a_s);
      dbg_q <= word_at(dbg_addr[IDX_W-1:0]);
    end
  end

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[byte_idx(wa_s, 2'(i))] <= wdata_s[8*(3-i) +: 8];
      end
    end
  end

  assign rd         = rd_q;
  assign dbg_rdata  = dbg_q;
  assign core_reset = core_reset_q;
  assign load_ready = load_ready_q;
  assign state      = state_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mips_unified_mem.sv
// Bench for mips_unified_mem: byte-array reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mips_unified_mem;

  localparam int MB = 128;

  logic        clk = 1'b0;
  logic        RESET;
  logic [31:0] adr, wd, load_addr, load_data, dbg_addr;
  logic        memwrite, load_valid, load_done;
  logic [31:0] rd, dbg_rdata, run_cycles;
  logic        core_reset, load_ready;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  mips_unified_mem dut (
    .clk(clk), .RESET(RESET), .adr(adr), .wd(wd), .memwrite(memwrite), .rd(rd),
    .core_reset(core_reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .state(state), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain byte array with per-byte "has been written" flags.
  logic [7:0]  ref_mem   [MB];
  bit          ref_known [MB];
  bit          m_valid = 1'b0;
  int          m_ph = 0;
  int          m_clr = 0;
  logic [31:0] m_run = 32'd0, m_rd = 32'd0, m_dbg = 32'd0;
  bit          m_rd_ok = 1'b0, m_dbg_ok = 1'b0;

  function automatic logic [31:0] word_of(input int a);
    word_of = {ref_mem[a % MB], ref_mem[(a + 1) % MB], ref_mem[(a + 2) % MB], ref_mem[(a + 3) % MB]};
  endfunction

  function automatic bit known_of(input int a);
    known_of = ref_known[a % MB] & ref_known[(a + 1) % MB] & ref_known[(a + 2) % MB] & ref_known[(a + 3) % MB];
  endfunction

  task automatic put_word(input int base, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      ref_mem[(base + i) % MB]   <= d[8*(3-i) +: 8];
      ref_known[(base + i) % MB] <= 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (RESET) begin
      m_valid <= 1'b1; m_ph <= 0; m_clr <= 0; m_run <= 32'd0;
      m_rd <= 32'd0; m_rd_ok <= 1'b1; m_dbg <= 32'd0; m_dbg_ok <= 1'b1;
    end else if (m_valid) begin
      m_rd     <= word_of((m_ph == 2) ? int'(adr[6:0]) : 0);
      m_rd_ok  <= known_of((m_ph == 2) ? int'(adr[6:0]) : 0);
      m_dbg    <= word_of(int'(dbg_addr[6:0]));
      m_dbg_ok <= known_of(int'(dbg_addr[6:0]));
      case (m_ph)
        0: begin
          put_word(m_clr * 4, 32'h0000_0000);
          m_clr <= m_clr + 1;
          if (m_clr == MB / 4 - 1) m_ph <= 1;
        end
        1: begin
          if (load_valid) put_word(int'({load_addr[6:2], 2'b00}), load_data);
          if (load_done) m_ph <= 2;
        end
        default: begin
          if (memwrite) put_word(int'(adr[6:0]), wd);
          if (m_run != 32'hFFFF_FFFF) m_run <= m_run + 32'd1;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_state", {30'd0, state}, 32'(m_ph));
      check("m_core_reset", {31'd0, core_reset}, {31'd0, (m_ph != 2)});
      check("m_load_ready", {31'd0, load_ready}, {31'd0, (m_ph == 1)});
      check("m_run_cycles", run_cycles, m_run);
      if (m_rd_ok)  check("m_rd", rd, m_rd);
      if (m_dbg_ok) check("m_dbg", dbg_rdata, m_dbg);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; adr = 32'h0; wd = 32'h0; memwrite = 1'b0; load_valid = 1'b0;
    load_addr = 32'h0; load_data = 32'h0; load_done = 1'b0; dbg_addr = 32'h0;
    tick(); tick();

    // Preload attempted during CLEAR must be refused and wiped.
    RESET = 1'b0; load_valid = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF; dbg_addr = 32'h20;
    for (int i = 0; i < 31; i++) begin
      tick();
      check("clr_state", {30'd0, state}, 32'd0);
      check("clr_ready", {31'd0, load_ready}, 32'd0);
    end
    load_valid = 1'b0;
    tick();
    check("boot_state", {30'd0, state}, 32'd1);
    check("boot_ready", {31'd0, load_ready}, 32'd1);
    check("clr_dbg20", dbg_rdata, 32'h0000_0000);

    // Core write strobe has no effect in BOOT.
    memwrite = 1'b1; adr = 32'h40; wd = 32'hFFFF_FFFF; dbg_addr = 32'h40;
    tick();
    memwrite = 1'b0;
    tick();
    check("boot_wr_ignored", dbg_rdata, 32'h0000_0000);

    // Program load; last word shares its cycle with load_done.
    adr = 32'h0;
    load(32'h00, 32'h8C01_0020);
    load(32'h04, 32'hAC01_0024);
    load(32'h20, 32'h0000_000F);
    load_done = 1'b1; dbg_addr = 32'h28;
    load(32'h28, 32'h0000_000C);
    load_done = 1'b0;
    check("run_state", {30'd0, state}, 32'd2);
    check("run_core_reset", {31'd0, core_reset}, 32'd0);
    tick();
    check("first_fetch", rd, 32'h8C01_0020);
    check("load_with_done", dbg_rdata, 32'h0000_000C);

    // Read-before-write, then post-write visibility.
    adr = 32'h24; wd = 32'h0000_000F; memwrite = 1'b1; dbg_addr = 32'h24;
    tick();
    check("rbw_rd", rd, 32'h0000_0000);
    check("rbw_dbg", dbg_rdata, 32'h0000_0000);
    memwrite = 1'b0;
    tick();
    check("wr_rd", rd, 32'h0000_000F);
    check("wr_dbg", dbg_rdata, 32'h0000_000F);

    // Preload port is dead in RUN.
    load_valid = 1'b1; load_addr = 32'h40; load_data = 32'hA5A5_A5A5; load_done = 1'b1; dbg_addr = 32'h40;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    tick();
    check("run_load_ignored", dbg_rdata, 32'h0000_0000);
    check("run_stays", {30'd0, state}, 32'd2);

    // Misaligned write wrapping past the top of the array.
    adr = 32'h7E; wd = 32'h1122_3344; memwrite = 1'b1;
    tick();
    memwrite = 1'b0; dbg_addr = 32'h00;
    tick();
    check("wrap_rd", rd, 32'h1122_3344);
    check("wrap_low", dbg_rdata, 32'h3344_0020);
    dbg_addr = 32'h7C;
    tick();
    check("wrap_high", dbg_rdata, 32'h0000_1122);

    // Mid-run reset, re-clear, and a fresh 10-cycle run.
    RESET = 1'b1;
    tick();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_run", run_cycles, 32'd0);
    check("rst_rd", rd, 32'd0);
    RESET = 1'b0; adr = 32'h0;
    repeat (32) tick();
    check("reclr_state", {30'd0, state}, 32'd1);
    tick();
    check("reclr_top", dbg_rdata, 32'h0000_0000);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    check("rerun_state", {30'd0, state}, 32'd2);
    repeat (10) tick();
    check("run_count10", run_cycles, 32'd10);

    // A write in the RESET cycle must not land.
    RESET = 1'b1; memwrite = 1'b1; adr = 32'h10; wd = 32'h1234_5678; dbg_addr = 32'h10;
    tick();
    check("rst2_run", run_cycles, 32'd0);
    RESET = 1'b0; memwrite = 1'b0;
    tick();
    check("rst_wr_suppressed", dbg_rdata, 32'h0000_0000);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
